// File: rtl/circular_buffer_writer_pkg.sv
// Shared types and constants for the circular buffer writer.
// The state encoding and the default geometry live here so that the top and
// the lane sub-module agree on word width and buffer shape.
package circular_buffer_writer_pkg;

    localparam int WORD_W = 16;
    localparam int LANES  = 8;
    localparam int SIZE   = 8;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        LOADED = 2'd2
    } cbw_state_e;

endpackage

// File: rtl/circular_buffer_writer_lane_mux.sv
// One lane of the circular buffer: SIZE words of storage, written one word
// at a time by column and read combinationally by the shared read pointer.
module cbw_lane_mux #(
    parameter int SIZE  = circular_buffer_writer_pkg::SIZE,
    parameter int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_wr_en,
    input  logic [PTR_W-1:0]                           i_wr_col,
    input  logic [circular_buffer_writer_pkg::WORD_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]                           i_rd_ptr,
    output logic [circular_buffer_writer_pkg::WORD_W-1:0] o_rd_data
);
    import circular_buffer_writer_pkg::*;

    logic [WORD_W-1:0] r_mem [SIZE];

    // Column storage: cleared by reset, otherwise written at the selected column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_col] <= i_wr_data;
        end
    end

    // Zero-latency read of the column under the read pointer.
    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/circular_buffer_writer.sv
// Circular buffer writer: fills a LANES x SIZE word array in row-major order
// (word n goes to lane n/SIZE, column n%SIZE), then exposes one column of all
// lanes at a time under a read pointer advanced by read_en.
// Optional feature macro: CIRCULAR_BUFFER_WRITER_AUTO_RELEASE_EN -- when
// defined, reading past the last column returns the buffer to EMPTY.
module circular_buffer_writer #(
    parameter int SIZE  = circular_buffer_writer_pkg::SIZE,
    parameter int LANES = circular_buffer_writer_pkg::LANES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        flush,
    input  logic        read_en,
    output logic [15:0] read_data_1,
    output logic [15:0] read_data_2,
    output logic [15:0] read_data_3,
    output logic [15:0] read_data_4,
    output logic [15:0] read_data_5,
    output logic [15:0] read_data_6,
    output logic [15:0] read_data_7,
    output logic [15:0] read_data_8,
    output logic        loaded
);
    import circular_buffer_writer_pkg::*;

    localparam int PTR_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W  = $clog2(LANES * SIZE);
    localparam int LANE_W = CNT_W - PTR_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LANES * SIZE - 1);
    localparam logic [PTR_W-1:0] LAST_COL  = PTR_W'(SIZE - 1);

    cbw_state_e         r_state;
    cbw_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   w_wr_cnt_nxt;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic               w_accept;
    logic [PTR_W-1:0]   w_wr_col;
    logic [LANE_W-1:0]  w_wr_lane;
    logic [WORD_W-1:0]  w_lane_data [LANES];

    // flush blocks acceptance in the same cycle so it always wins over wr_valid.
    assign wr_ready  = (r_state != LOADED) && !flush;
    assign loaded    = (r_state == LOADED);
    assign w_accept  = wr_valid && wr_ready;
    assign w_wr_col  = r_wr_cnt[PTR_W-1:0];
    assign w_wr_lane = r_wr_cnt[CNT_W-1:PTR_W];

    // Next-state, write-counter and read-pointer decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_ptr_nxt = r_rd_ptr;
        if (flush) begin
            w_state_nxt  = EMPTY;
            w_wr_cnt_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = FILL;
                        w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                    end else begin
                        w_state_nxt  = EMPTY;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        // The counter wraps to zero on the last word, ready for the next fill.
                        w_wr_cnt_nxt = r_wr_cnt + CNT_W'(1);
                        if (r_wr_cnt == LAST_WORD) begin
                            w_state_nxt = LOADED;
                        end else begin
                            w_state_nxt = FILL;
                        end
                    end else begin
                        w_state_nxt = FILL;
                    end
                end
                LOADED: begin
                    if (read_en) begin
                        if (r_rd_ptr == LAST_COL) begin
                            w_rd_ptr_nxt = '0;
`ifdef CIRCULAR_BUFFER_WRITER_AUTO_RELEASE_EN
                            w_state_nxt  = EMPTY;
                            w_wr_cnt_nxt = '0;
`else
                            w_state_nxt  = LOADED;
`endif
                        end else begin
                            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
                        end
                    end else begin
                        w_rd_ptr_nxt = r_rd_ptr;
                    end
                end
                default: begin
                    w_state_nxt  = EMPTY;
                    w_wr_cnt_nxt = '0;
                    w_rd_ptr_nxt = '0;
                end
            endcase
        end
    end

    // State, write counter and read pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_wr_cnt <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cbw_lane_mux #(
            .SIZE  (SIZE),
            .PTR_W (PTR_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_accept && (w_wr_lane == LANE_W'(l))),
            .i_wr_col  (w_wr_col),
            .i_wr_data (wr_data),
            .i_rd_ptr  (r_rd_ptr),
            .o_rd_data (w_lane_data[l])
        );
    end

    assign read_data_1 = w_lane_data[0];
    assign read_data_2 = w_lane_data[1];
    assign read_data_3 = w_lane_data[2];
    assign read_data_4 = w_lane_data[3];
    assign read_data_5 = w_lane_data[4];
    assign read_data_6 = w_lane_data[5];
    assign read_data_7 = w_lane_data[6];
    assign read_data_8 = w_lane_data[7];

endmodule

// File: doc/circular_buffer_writer.md
CIRCULAR_BUFFER_WRITER -- requirements
Module: circular_buffer_writer

Interface
REQ-001 Parameter SIZE, default 8, column depth per lane (read_ptr range 0..SIZE-1).
REQ-002 Parameter LANES, default 8, number of parallel lanes; fixed to 8 by the read_data_1..8 ports.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  producer offers wr_data this cycle.
REQ-006 wr_data  input  16  word to store.
REQ-007 wr_ready  output  1  block accepts wr_data this cycle.
REQ-008 flush  input  1  discard contents and return to EMPTY.
REQ-009 read_en  input  1  advance the read column pointer.
REQ-010 read_data_1..read_data_8  output  16 each  lane k (1..8) word at the current read column.
REQ-011 loaded  output  1  all LANES*SIZE words are stored and the read side is live.

Function
REQ-012 A word SHALL be accepted when wr_valid and wr_ready are both high on a rising clock edge.
REQ-013 The n-th accepted word (n = 0..63) SHALL be written to lane n/8, column n%8 (row-major: 8*lane+column).
REQ-014 The FSM SHALL have three states: EMPTY, FILL, LOADED.
REQ-015 EMPTY SHALL go to FILL on the first accepted word; that word is stored at lane 0, column 0.
REQ-016 FILL SHALL go to LOADED on the edge that accepts word 63; loaded SHALL rise the following cycle.
REQ-017 wr_ready SHALL be 1 in EMPTY and FILL, and 0 in LOADED and in any cycle where flush is high.
REQ-018 A 6-bit write counter SHALL increment per accepted word and SHALL be cleared on entering EMPTY.
REQ-019 read_data_k SHALL be a combinational read of storage[k-1][read_ptr], giving zero-latency output.
REQ-020 In LOADED, read_en SHALL advance read_ptr by 1 modulo SIZE (7 wraps to 0).
REQ-021 read_en SHALL be ignored in EMPTY and FILL; read_ptr holds at 0.
REQ-022 flush SHALL move the FSM to EMPTY from any state and clear read_ptr and the write counter; storage is not cleared.
REQ-023 flush together with wr_valid: flush wins and no word is accepted.
REQ-024 flush together with read_en: flush wins and read_ptr becomes 0.
REQ-025 wr_valid in LOADED SHALL have no effect (wr_ready is 0).

Reset
REQ-026 rst SHALL force: state EMPTY, write counter 0, read_ptr 0, all 64 storage words 0.
REQ-027 Resulting output values under reset: wr_ready 1, loaded 0, read_data_1..8 = 0.
REQ-028 rst asserted mid-FILL or mid-read SHALL discard all progress immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro CIRCULAR_BUFFER_WRITER_AUTO_RELEASE_EN controls release after reading.
REQ-030 Macro defined: in LOADED, read_en with read_ptr == SIZE-1 SHALL wrap read_ptr to 0 and return the FSM to EMPTY (single-pass consume).
REQ-031 Macro undefined: read_ptr wraps indefinitely; LOADED is left only by flush or rst.

Structure
REQ-032 A shared package SHALL hold the state encoding type (EMPTY/FILL/LOADED) and the constants WORD_W=16, LANES=8, SIZE=8.
REQ-033 Storage SHALL be a LANES x SIZE register array.
REQ-034 One sub-module, cbw_lane_mux, SHALL hold one lane's SIZE words and select by read_ptr; it is instantiated LANES times.

Verification
REQ-035 Reset, then stream words 0x0000..0x003F with wr_valid held high -> loaded=1 after 64 accepts; read_data_1..8 = 0x0000,0x0008,...,0x0038.
REQ-036 After loading, pulse read_en 3 times -> read_data_1=0x0003, read_data_8=0x003B; pulse 5 more -> pointer wraps, read_data_1=0x0000 (macro undefined).
REQ-037 Macro defined: 8 read_en pulses after load -> loaded=0, wr_ready=1; the next accepted word is stored at lane 0, column 0.
REQ-038 Assert flush and wr_valid together at word 20 -> word not accepted, state EMPTY; the next word is stored at lane 0, column 0.
REQ-039 Assert rst asynchronously mid-FILL at word 40 -> wr_ready=1, loaded=0, all read_data = 0 before the next clock edge.
REQ-040 Drive wr_valid=1 with data 0xBEEF while in LOADED -> wr_ready=0 and storage unchanged.
